arbitro_escrita_banco: RTL and testbench

Write-port arbiter and pending-write scoreboard for the ID-stage `register_file`. Two producers share the file's single write port: port 0 is the pipeline writeback path and port 1 is a multi-cycle unit. The block accepts writes through valid/ready handshakes and grants one write per cycle with round-robin fairness. It drives `habilita_escrita`, `endereco_destino` and `dado_escrita` from registers, and can optionally track which destinations still have writes outstanding so the hazard unit can stall.

---
 rtl/arbitro_escrita_banco_if.sv | 31 +++
 rtl/arbitro_escrita_banco.sv | 121 ++++++++++++
 tb/tb_arbitro_escrita_banco.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_escrita_banco_if.sv
// Write-request handshakes of the two producers plus the registered write port toward register_file.
interface arbitro_escrita_banco_if #(
    parameter int LARGURA_DADO = 32,
    parameter int LARGURA_END  = 5
);
    logic                    req0_valido;
    logic [LARGURA_END-1:0]  req0_endereco;
    logic [LARGURA_DADO-1:0] req0_dado;
    logic                    req0_pronto;
    logic                    req1_valido;
    logic [LARGURA_END-1:0]  req1_endereco;
    logic [LARGURA_DADO-1:0] req1_dado;
    logic                    req1_pronto;
    logic                    habilita_escrita;
    logic [LARGURA_END-1:0]  endereco_destino;
    logic [LARGURA_DADO-1:0] dado_escrita;

    modport master (
        output req0_valido, req0_endereco, req0_dado,
        output req1_valido, req1_endereco, req1_dado,
        input  req0_pronto, req1_pronto,
        input  habilita_escrita, endereco_destino, dado_escrita
    );

    modport slave (
        input  req0_valido, req0_endereco, req0_dado,
        input  req1_valido, req1_endereco, req1_dado,
        output req0_pronto, req1_pronto,
        output habilita_escrita, endereco_destino, dado_escrita
    );
endinterface

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter for the register_file write port, with an optional pending-write
// scoreboard enabled by defining ARB_SCOREBOARD_EN.
module arbitro_escrita_banco #(
    parameter int LARGURA_DADO = 32,
    parameter int LARGURA_END  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    arbitro_escrita_banco_if.slave bus,
    input  logic                   reserva_valida,
    input  logic [LARGURA_END-1:0] reserva_endereco,
    input  logic [LARGURA_END-1:0] consulta_fonte1,
    input  logic [LARGURA_END-1:0] consulta_fonte2,
    output logic                   pendente_fonte1,
    output logic                   pendente_fonte2,
    output logic                   erro_reserva
);

    typedef enum logic {PRIO0, PRIO1} estado_t;

    estado_t                 estado;
    logic                    concede0;
    logic                    concede1;
    logic                    transfere;
    logic [LARGURA_END-1:0]  end_sel;
    logic [LARGURA_DADO-1:0] dado_sel;
    logic                    habilita_q;
    logic [LARGURA_END-1:0]  endereco_q;
    logic [LARGURA_DADO-1:0] dado_q;

    // A lone requester always wins; the state only breaks ties. Grants are masked in reset.
    always_comb begin
        concede0  = reset && bus.req0_valido && (!bus.req1_valido || estado == PRIO0);
        concede1  = reset && bus.req1_valido && (!bus.req0_valido || estado == PRIO1);
        transfere = concede0 || concede1;
        end_sel   = concede1 ? bus.req1_endereco : bus.req0_endereco;
        dado_sel  = concede1 ? bus.req1_dado : bus.req0_dado;
    end

    assign bus.req0_pronto      = concede0;
    assign bus.req1_pronto      = concede1;
    assign bus.habilita_escrita = habilita_q;
    assign bus.endereco_destino = endereco_q;
    assign bus.dado_escrita     = dado_q;

    // A grant to x0 is consumed but never enables the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= PRIO0;
            habilita_q <= 1'b0;
            endereco_q <= '0;
            dado_q     <= '0;
        end else begin
            if (concede0) begin
                estado <= PRIO1;
            end else if (concede1) begin
                estado <= PRIO0;
            end
            habilita_q <= transfere && (end_sel != '0);
            if (transfere) begin
                endereco_q <= end_sel;
                dado_q     <= dado_sel;
            end
        end
    end

`ifdef ARB_SCOREBOARD_EN
    localparam int NUM_REG = 1 << LARGURA_END;

    logic [1:0]         contador [NUM_REG];
    logic [NUM_REG-1:0] inc_vec;
    logic [NUM_REG-1:0] dec_vec;
    logic               erro_q;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (reserva_valida && reserva_endereco != '0) begin
            inc_vec[reserva_endereco] = 1'b1;
        end
        if (transfere && end_sel != '0) begin
            dec_vec[end_sel] = 1'b1;
        end
    end

    // Simultaneous reserve and retire on one register cancel out; x0 is never marked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erro_q <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                contador[i] <= 2'd0;
            end
        end else begin
            erro_q <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (contador[i] == 2'd3) begin
                        erro_q <= 1'b1;
                    end else begin
                        contador[i] <= contador[i] + 2'd1;
                    end
                end else if (dec_vec[i] && !inc_vec[i] && contador[i] != 2'd0) begin
                    contador[i] <= contador[i] - 2'd1;
                end
            end
        end
    end

    assign pendente_fonte1 = (consulta_fonte1 != '0) && (contador[consulta_fonte1] != 2'd0);
    assign pendente_fonte2 = (consulta_fonte2 != '0) && (contador[consulta_fonte2] != 2'd0);
    assign erro_reserva    = erro_q;
`else
    logic unused_entradas;

    assign unused_entradas = ^{reserva_valida, reserva_endereco, consulta_fonte1, consulta_fonte2};
    assign pendente_fonte1 = 1'b0;
    assign pendente_fonte2 = 1'b0;
    assign erro_reserva    = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Scoreboard bench for arbitro_escrita_banco: a reference model queues the expected write-port
// state each cycle and every scenario task compares the DUT against it.
module tb_arbitro_escrita_banco;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
    } saida_t;

    typedef struct packed {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  q;
        logic        pend;
    } passo_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       reserva_valida;
    logic [4:0] reserva_endereco;
    logic [4:0] consulta_fonte1;
    logic [4:0] consulta_fonte2;
    logic       pendente_fonte1;
    logic       pendente_fonte2;
    logic       erro_reserva;

    int errors = 0;
    int checks = 0;

    saida_t      exp_q [$];
    logic        m_prio;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_cnt [32];

    logic        obs_g0, obs_g1, exp_g0, exp_g1, obs_en, obs_err;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

`ifdef ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    arbitro_escrita_banco_if #(.LARGURA_DADO(32), .LARGURA_END(5)) bus ();

    arbitro_escrita_banco #(.LARGURA_DADO(32), .LARGURA_END(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .reserva_valida   (reserva_valida),
        .reserva_endereco (reserva_endereco),
        .consulta_fonte1  (consulta_fonte1),
        .consulta_fonte2  (consulta_fonte2),
        .pendente_fonte1  (pendente_fonte1),
        .pendente_fonte2  (pendente_fonte2),
        .erro_reserva     (erro_reserva)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_prio = 1'b0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 2'd0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.req0_valido   = 1'b0;
        bus.req0_endereco = '0;
        bus.req0_dado     = '0;
        bus.req1_valido   = 1'b0;
        bus.req1_endereco = '0;
        bus.req1_dado     = '0;
        reserva_valida    = 1'b0;
        reserva_endereco  = '0;
    endtask

    // Called at a falling edge; holds reset low across one rising edge.
    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drives one cycle at a falling edge, advances the model and queues the expected outputs.
    task automatic ciclo(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic rv, input logic [4:0] ra);
        saida_t e;
        logic   dv;
        bus.req0_valido   = v0;
        bus.req0_endereco = a0;
        bus.req0_dado     = d0;
        bus.req1_valido   = v1;
        bus.req1_endereco = a1;
        bus.req1_dado     = d1;
        reserva_valida    = rv;
        reserva_endereco  = ra;
        #1;
        obs_g0 = bus.req0_pronto;
        obs_g1 = bus.req1_pronto;
        exp_g0 = v0 && (!v1 || !m_prio);
        exp_g1 = v1 && (!v0 || m_prio);
        dv     = 1'b0;
        e      = '0;
        if (exp_g0) begin
            m_addr = a0; m_data = d0; dv = 1'b1; m_prio = 1'b1;
        end else if (exp_g1) begin
            m_addr = a1; m_data = d1; dv = 1'b1; m_prio = 1'b0;
        end
        e.en   = dv && (m_addr != 5'd0);
        e.addr = m_addr;
        e.data = m_data;
`ifdef ARB_SCOREBOARD_EN
        if (rv && ra != 5'd0 && !(e.en && m_addr == ra)) begin
            if (m_cnt[ra] == 2'd3) e.err = 1'b1;
            else m_cnt[ra] = m_cnt[ra] + 2'd1;
        end
        if (e.en && !(rv && ra == m_addr) && m_cnt[m_addr] != 2'd0)
            m_cnt[m_addr] = m_cnt[m_addr] - 2'd1;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_en   = bus.habilita_escrita;
        obs_addr = bus.endereco_destino;
        obs_data = bus.dado_escrita;
        obs_err  = erro_reserva;
        @(negedge clk);
    endtask

    task automatic test_reset();
        saida_t e;
        reset = 1'b1;
        drive_idle();
        consulta_fonte1 = 5'd1;
        consulta_fonte2 = 5'd1;
        #2;
        reset = 1'b0;
        bus.req0_valido   = 1'b1;
        bus.req0_endereco = 5'd1;
        bus.req0_dado     = 32'hA5A5A5A5;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.req0_pronto !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pronto: got %b want 0", bus.req0_pronto);
        end
        checks++;
        if ({bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita, erro_reserva, pendente_fonte1} !== 40'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: en=%b addr=%0d data=%h err=%b pend=%b want all 0",
                     bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita, erro_reserva, pendente_fonte1);
        end
        @(negedge clk);
        reset = 1'b1;
        ciclo(1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_g0 !== 1'b1 || obs_g1 !== 1'b0) begin
            errors++; $display("[TB] FAIL first_grant: pronto0/1=%b%b want 10", obs_g0, obs_g1);
        end
        checks++;
        if ({obs_en, obs_addr, obs_data} !== {1'b1, 5'd1, 32'hA5A5A5A5}) begin
            errors++; $display("[TB] FAIL first_write: en=%b addr=%0d data=%h want 1 1 a5a5a5a5", obs_en, obs_addr, obs_data);
        end
        checks++;
        if ({obs_en, obs_addr, obs_data, obs_err} !== e) begin
            errors++; $display("[TB] FAIL first_write_sb: got %h want %h", {obs_en, obs_addr, obs_data, obs_err}, e);
        end
    endtask

    task automatic test_contention();
        saida_t      e;
        logic [31:0] d0 [3] = '{32'h5A5A5A5A, 32'h5A5A5A5B, 32'h5A5A5A5C};
        logic [31:0] d1 [3] = '{32'h12345678, 32'h12345679, 32'h1234567A};
        int i0 = 0;
        int i1 = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            ciclo(i0 < 3, 5'd2, d0[i0 % 3], i1 < 3, 5'd3, d1[i1 % 3], 1'b0, 5'd0);
            if (exp_g0) i0++;
            if (exp_g1) i1++;
            e = exp_q.pop_front();
            checks++;
            if (c < 6 && (obs_g0 !== !c[0] || obs_g1 !== c[0])) begin
                errors++; $display("[TB] FAIL contention_grant c%0d: pronto0/1=%b%b want %b%b", c, obs_g0, obs_g1, !c[0], c[0]);
            end else if (c == 6 && (obs_g0 | obs_g1) !== 1'b0) begin
                errors++; $display("[TB] FAIL contention_idle_grant: pronto0/1=%b%b want 00", obs_g0, obs_g1);
            end
            checks++;
            if ({obs_en, obs_addr, obs_data, obs_err} !== e) begin
                errors++; $display("[TB] FAIL contention_write c%0d: got %h want %h", c, {obs_en, obs_addr, obs_data, obs_err}, e);
            end
        end
    endtask

    task automatic test_x0_write();
        saida_t e;
        do_reset();
        ciclo(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0);
        e = exp_q.pop_front();
        checks++;
        if (obs_g1 !== 1'b1 || obs_g0 !== 1'b0) begin
            errors++; $display("[TB] FAIL x0_grant: pronto0/1=%b%b want 01", obs_g0, obs_g1);
        end
        checks++;
        if (obs_en !== 1'b0 || {obs_en, obs_addr, obs_data, obs_err} !== e) begin
            errors++; $display("[TB] FAIL x0_write: got %h want %h", {obs_en, obs_addr, obs_data, obs_err}, e);
        end
    endtask

    task automatic test_priority_after_solo();
        saida_t e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ciclo(c < 4, 5'd4, 32'h44440000 + c, c == 3, 5'd10, 32'hAAAA0010, 1'b0, 5'd0);
            e = exp_q.pop_front();
            checks++;
            if ({obs_g0, obs_g1} !== {exp_g0, exp_g1} || (c == 3 && obs_g1 !== 1'b1)) begin
                errors++; $display("[TB] FAIL solo_grant c%0d: pronto0/1=%b%b want %b%b", c, obs_g0, obs_g1, exp_g0, exp_g1);
            end
            checks++;
            if ({obs_en, obs_addr, obs_data, obs_err} !== e) begin
                errors++; $display("[TB] FAIL solo_write c%0d: got %h want %h", c, {obs_en, obs_addr, obs_data, obs_err}, e);
            end
        end
    endtask

    task automatic test_scoreboard();
        saida_t e;
        passo_t tbl [13];
        int     n_err = 0;
        tbl = '{
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b1},
            '{1'b1, 5'd5, 32'h55550001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55550002, 1'b0, 5'd0, 5'd5, 1'b0},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1},
            '{1'b1, 5'd7, 32'h77770001, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1},
            '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77770002, 1'b0, 5'd0, 5'd7, 1'b0},
            '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0}
        };
        do_reset();
        for (int s = 0; s < 13; s++) begin
            ciclo(tbl[s].v0, tbl[s].a0, tbl[s].d0, tbl[s].v1, tbl[s].a1, tbl[s].d1, tbl[s].rv, tbl[s].ra);
            e = exp_q.pop_front();
            if (obs_err === 1'b1) n_err++;
            checks++;
            if ({obs_en, obs_addr, obs_data, obs_err} !== e) begin
                errors++; $display("[TB] FAIL sb_write s%0d: got %h want %h", s, {obs_en, obs_addr, obs_data, obs_err}, e);
            end
            consulta_fonte1 = tbl[s].q;
            consulta_fonte2 = tbl[s].q;
            #1;
            checks++;
            if (pendente_fonte1 !== (SB & tbl[s].pend) || pendente_fonte2 !== (SB & tbl[s].pend)) begin
                errors++;
                $display("[TB] FAIL sb_pendente s%0d x%0d: pend1=%b pend2=%b want %b", s, tbl[s].q,
                         pendente_fonte1, pendente_fonte2, SB & tbl[s].pend);
            end
        end
        checks++;
        if (n_err !== (SB ? 1 : 0)) begin
            errors++; $display("[TB] FAIL sb_overflow_pulses: got %0d want %0d", n_err, SB ? 1 : 0);
        end
    endtask

    task automatic test_reset_inflight();
        saida_t e;
        do_reset();
        ciclo(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        void'(exp_q.pop_front());
        ciclo(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        void'(exp_q.pop_front());
        ciclo(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        e = exp_q.pop_front();
        consulta_fonte1 = 5'd9;
        #1;
        checks++;
        if ({bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita} !== {e.en, e.addr, e.data} || !e.en
            || pendente_fonte1 !== SB) begin
            errors++;
            $display("[TB] FAIL inflight_before: en=%b addr=%0d data=%h pend=%b want 1 9 cafef00d %b",
                     bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita, pendente_fonte1, SB);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita, bus.req0_pronto, pendente_fonte1} !== 40'd0) begin
            errors++;
            $display("[TB] FAIL inflight_cancel: en=%b addr=%0d data=%h pronto0=%b pend=%b want all 0",
                     bus.habilita_escrita, bus.endereco_destino, bus.dado_escrita, bus.req0_pronto, pendente_fonte1);
        end
        @(negedge clk);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_x0_write();
        test_priority_after_solo();
        test_scoreboard();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
